// File: rtl/wb_relay_guard.sv
// rtl/wb_relay_guard.sv - Wishbone relay driver with per-channel min on/off lockouts
// Outputs follow the request register only when lockouts and the exclusion mask allow.
module wb_relay_guard #(
  parameter int              N_CH      = 8,
  parameter int              TICK_DIV  = 50_000_000,
  parameter int              MIN_ON    = 60,
  parameter int              MIN_OFF   = 180,
  parameter logic [N_CH-1:0] EXCL_MASK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_cyc,
  input  logic            wb_stb,
  input  logic            wb_we,
  input  logic [1:0]      wb_adr,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack,
  output logic [N_CH-1:0] relay_out
);

  localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [15:0] ON_LD   = 16'(MIN_ON);
  localparam logic [15:0] OFF_LD  = 16'(MIN_OFF);

  // bit 1 of the encoding is the relay drive itself
  typedef enum logic [1:0] {
    OFF_LOCK  = 2'b00,
    OFF_READY = 2'b01,
    ON_LOCK   = 2'b10,
    ON_READY  = 2'b11
  } ch_state_t;

  ch_state_t       state_q [N_CH];
  ch_state_t       state_d [N_CH];
  logic [15:0]     cnt_q   [N_CH];
  logic [15:0]     cnt_d   [N_CH];
  logic [PW-1:0]   ps_q;
  logic [N_CH-1:0] req_q;
  logic [N_CH-1:0] relay;
  logic            force_q;
  logic            tick;
  logic            bus_hit;
  logic            wr;
  logic            rd;
  logic            excl_busy;
  logic            granted;
  logic            unused_ok;

  assign tick      = (ps_q == PS_LAST);
  assign bus_hit   = wb_cyc & wb_stb & ~wb_ack;
  assign wr        = bus_hit & wb_we;
  assign rd        = bus_hit & ~wb_we;
  assign relay_out = relay;
  assign unused_ok = ^wb_dat_i;

  always_comb begin
    relay = '0;
    for (int i = 0; i < N_CH; i++) relay[i] = state_q[i][1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q     <= '0;
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
      req_q    <= '0;
      force_q  <= 1'b0;
    end else begin
      ps_q    <= tick ? '0 : ps_q + 1'b1;
      wb_ack  <= bus_hit;
      // force-off takes effect on the edge after the CTRL write commits
      force_q <= wr && (wb_adr == 2'd3) && wb_dat_i[0];
      if (wr) begin
        case (wb_adr)
          2'd0:    req_q <= wb_dat_i[N_CH-1:0];
          2'd3:    if (wb_dat_i[0]) req_q <= '0;
          default: ;
        endcase
      end
      if (rd) begin
        case (wb_adr)
          2'd0:    wb_dat_o <= 32'(req_q);
          2'd1:    wb_dat_o <= 32'(relay);
          2'd2:    wb_dat_o <= 32'(req_q ^ relay);
          default: wb_dat_o <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!rst_n) begin
        state_q[i] <= (OFF_LD == 16'd0) ? OFF_READY : OFF_LOCK;
        cnt_q[i]   <= OFF_LD;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    excl_busy = |(relay & EXCL_MASK);
    granted   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_q && state_q[i][1]) begin
        state_d[i] = (OFF_LD == 16'd0) ? OFF_READY : OFF_LOCK;
        cnt_d[i]   = OFF_LD;
      end else begin
        case (state_q[i])
          OFF_LOCK, ON_LOCK: begin
            if (tick) begin
              if (cnt_q[i] <= 16'd1)
                state_d[i] = (state_q[i] == OFF_LOCK) ? OFF_READY : ON_READY;
              else
                cnt_d[i] = cnt_q[i] - 16'd1;
            end
          end
          OFF_READY: begin
            // lowest eligible exclusive channel wins; later ones see granted
            if (req_q[i] && (!EXCL_MASK[i] || (!excl_busy && !granted))) begin
              if (EXCL_MASK[i]) granted = 1'b1;
              state_d[i] = (ON_LD == 16'd0) ? ON_READY : ON_LOCK;
              cnt_d[i]   = ON_LD;
            end
          end
          ON_READY: begin
            if (!req_q[i]) begin
              state_d[i] = (OFF_LD == 16'd0) ? OFF_READY : OFF_LOCK;
              cnt_d[i]   = OFF_LD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_relay_guard.sv
// tb/tb_wb_relay_guard.sv - scoreboard bench for wb_relay_guard
// Reads push expected data; acks pop and compare. Lockout timing is checked in edges from reset release.
module tb_wb_relay_guard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [1:0]  wb_adr = 2'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack;
  logic [3:0]  relay_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;
  logic [31:0] exp_q[$];

  wb_relay_guard #(
    .N_CH(4), .TICK_DIV(4), .MIN_ON(3), .MIN_OFF(2), .EXCL_MASK(4'b0101)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .relay_out(relay_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // called #1 after an edge; returns #1 after the ack edge with the bus idle
  task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] d, output int commit);
    int g;
    logic [31:0] e;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = d;
    g = 0;
    do begin
      @(posedge clk); #1; g++;
    end while (!wb_ack && g < 16);
    commit = cyc_n;
    if (!we) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      if (!wb_ack) chk("bus_timeout", {31'd0, wb_ack}, 32'd1);
      else chk($sformatf("rd_adr%0d", adr), wb_dat_o, e);
    end else if (!wb_ack) begin
      chk("bus_timeout", {31'd0, wb_ack}, 32'd1);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] adr, input logic [31:0] d);
    int c;
    bus(1'b1, adr, d, c);
  endtask

  task automatic bus_read(input logic [1:0] adr, input logic [31:0] e);
    int c;
    exp_q.push_back(e);
    bus(1'b0, adr, 32'd0, c);
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_relay(input int limit, output int at);
    logic [3:0] prev;
    int g;
    prev = relay_out;
    g = 0;
    while (relay_out == prev && g < limit) begin
      @(posedge clk); #1; g++;
    end
    at = cyc_n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int at;
    int c;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_relay", {28'd0, relay_out}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);

    // power-on lockout
    base = cyc_n; rst_n = 1'b1;
    bus_write(2'd0, 32'h2);
    chk("pwr_hold", {28'd0, relay_out}, 32'd0);
    wait_relay(20, at);
    chk("pwr_on_at", at - base, 32'd9);
    chk("pwr_on_val", {28'd0, relay_out}, 32'h2);
    bus_read(2'd2, 32'h0);

    // minimum on-time, then minimum off-time on re-request
    wait_until(base + 13);
    bus_write(2'd0, 32'h0);
    wait_relay(20, at);
    chk("minon_off_at", at - base, 32'd21);
    chk("minon_off_val", {28'd0, relay_out}, 32'h0);
    bus_write(2'd0, 32'h2);
    wait_relay(20, at);
    chk("minoff_on_at", at - base, 32'd29);
    chk("minoff_on_val", {28'd0, relay_out}, 32'h2);

    // exclusion
    rst_n = 1'b0; @(posedge clk); #1; base = cyc_n; rst_n = 1'b1;
    wait_until(base + 10);
    bus_write(2'd0, 32'h5);
    wait_relay(20, at);
    chk("excl_on_at", at - base, 32'd12);
    chk("excl_on_val", {28'd0, relay_out}, 32'h1);
    bus_write(2'd0, 32'h4);
    wait_relay(30, at);
    chk("excl_drop_at", at - base, 32'd25);
    chk("excl_drop_val", {28'd0, relay_out}, 32'h0);
    wait_relay(5, at);
    chk("excl_swap_at", at - base, 32'd26);
    chk("excl_swap_val", {28'd0, relay_out}, 32'h4);

    // force-off during ON_LOCK, coinciding with a tick
    rst_n = 1'b0; @(posedge clk); #1; base = cyc_n; rst_n = 1'b1;
    wait_until(base + 10);
    bus_write(2'd0, 32'h3);
    wait_relay(20, at);
    chk("force_pre_at", at - base, 32'd12);
    chk("force_pre_val", {28'd0, relay_out}, 32'h3);
    wait_until(base + 14);
    bus(1'b1, 2'd3, 32'h1, c);
    chk("force_commit_at", c - base, 32'd15);
    chk("force_commit_hold", {28'd0, relay_out}, 32'h3);
    @(posedge clk); #1;
    chk("force_off", {28'd0, relay_out}, 32'h0);
    bus_read(2'd0, 32'h0);
    bus_write(2'd0, 32'h3);
    wait_relay(20, at);
    chk("force_relock_at", at - base, 32'd25);
    chk("force_relock_val", {28'd0, relay_out}, 32'h3);

    // reset during ON_LOCK with a read in flight
    wait_until(base + 27);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack", {31'd0, wb_ack}, 32'd0);
    chk("midrst_relay", {28'd0, relay_out}, 32'h0);
    base = cyc_n; rst_n = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ack2", {31'd0, wb_ack}, 32'd0);
    bus_read(2'd0, 32'h0);
    bus_write(2'd0, 32'h2);
    wait_relay(20, at);
    chk("midrst_relock_at", at - base, 32'd9);
    chk("midrst_relock_val", {28'd0, relay_out}, 32'h2);

    // held strobe: ack every other cycle
    repeat (3) exp_q.push_back(32'h2);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("burst_ack%0d", k), {31'd0, wb_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (wb_ack && exp_q.size() > 0) chk($sformatf("burst_dat%0d", k), wb_dat_o, exp_q.pop_front());
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;

    // read-only registers ignore writes; unused REQ bits read 0
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd0, 32'hFFFF_FFF2);
    bus_read(2'd0, 32'h2);
    bus_read(2'd1, 32'h2);
    bus_read(2'd2, 32'h0);
    bus_read(2'd3, 32'h0);
    chk("final_relay", {28'd0, relay_out}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
